// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the round-robin decoder-select arbiter.
// The optional hold timeout is enabled with the DEC_ARB_TIMEOUT_EN macro.
package dec_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    // Pointer value after reset so that requester 0 is searched first
    localparam logic [IDX_W-1:0] RST_LAST = IDX_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/dec_grant_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit after `last`, wrapping.
module rr_pick
    import dec_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    // Walk offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        winner = '0;
        any    = |req;
        for (int unsigned i = N_REQ; i >= 1; i--) begin
            if (req[IDX_W'(last + IDX_W'(i))]) begin
                winner = IDX_W'(last + IDX_W'(i));
            end
        end
    end

endmodule

// File: rtl/dec_grant_arbiter.sv
// Round-robin arbiter driving the 3-to-8 decoder select/enable from registers.
// Define DEC_ARB_TIMEOUT_EN to build the MAX_HOLD force-release counter.
module dec_grant_arbiter
    import dec_arb_pkg::*;
`ifdef DEC_ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [IDX_W-1:0] dec_in,
    output logic             dec_en,
    output logic             busy,
    output logic             timeout
);

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] winner;
    logic             any;
    logic             release_c;

    rr_pick u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    // Only the current owner's request and done bits can end a grant
    assign release_c = done[dec_in] | ~req[dec_in];

`ifdef DEC_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       hold_expired_c;

    assign hold_expired_c = (hold_cnt == HOLD_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last    <= RST_LAST;
            dec_in  <= '0;
            dec_en  <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        state  <= ST_GRANT;
                        last   <= winner;
                        dec_in <= winner;
                        dec_en <= 1'b1;
                        busy   <= 1'b1;
`ifdef DEC_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // A normal release outranks an expiry in the same cycle
                    if (release_c) begin
                        state  <= ST_GAP;
                        dec_en <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
                    end else if (hold_expired_c) begin
                        state   <= ST_GAP;
                        dec_en  <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
`endif
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    dec_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_grant_arbiter.sv
// Directed bench for dec_grant_arbiter: per-cycle vector table plus hand-written
// round-robin and long-hold sequences (behaviour depends on DEC_ARB_TIMEOUT_EN).
module tb_dec_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic [2:0] dec_in;
    logic       dec_en;
    logic       busy;
    logic       timeout;

    int unsigned tests;
    int unsigned fails;

`ifdef DEC_ARB_TIMEOUT_EN
    dec_grant_arbiter #(.MAX_HOLD(16)) dut (
`else
    dec_grant_arbiter dut (
`endif
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .dec_in  (dec_in),
        .dec_en  (dec_en),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] done;
        logic [2:0] exp_in;
        logic       exp_en;
        logic       exp_busy;
        logic       exp_to;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] dn,
                       input logic [2:0] ei, input logic ee, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.done = dn;
        v.exp_in = ei; v.exp_en = ee; v.exp_busy = eb; v.exp_to = 1'b0;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input int n, input logic [2:0] ei,
                         input logic ee, input logic eb, input logic et);
        tests++;
        if (dec_in !== ei || dec_en !== ee || busy !== eb || timeout !== et) begin
            fails++;
            $display("FAIL %s[%0d]: got in=%0d en=%0b busy=%0b to=%0b, want in=%0d en=%0b busy=%0b to=%0b",
                     nm, n, dec_in, dec_en, busy, timeout, ei, ee, eb, et);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Apply inputs, take one edge, sample 1 time unit later
    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] dn);
        rst = r; req = rq; done = dn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        int to_cnt;
        int fell;
        tests = 0;
        fails = 0;
        rst = 1'b1; req = '0; done = '0;

        // rst, req, done -> dec_in, dec_en, busy
        add(1, 8'h00, 8'h00, 0, 0, 0);   // reset values
        add(0, 8'h01, 8'h00, 0, 1, 1);   // grant 0
        add(0, 8'h01, 8'h01, 0, 0, 1);   // done[0] -> GAP
        add(0, 8'h00, 8'h00, 0, 0, 0);   // IDLE
        add(0, 8'h00, 8'hFF, 0, 0, 0);   // stray done in IDLE ignored
        add(0, 8'h08, 8'h00, 3, 1, 1);   // grant 3
        add(0, 8'h28, 8'h20, 3, 1, 1);   // done[5] from non-owner ignored
        add(0, 8'h28, 8'h00, 3, 1, 1);   // no preemption
        add(0, 8'h20, 8'h00, 3, 0, 1);   // req[3] dropped -> GAP
        add(0, 8'h20, 8'h00, 3, 0, 0);   // IDLE keeps dec_in
        add(0, 8'h20, 8'h00, 5, 1, 1);   // grant 5
        add(0, 8'h20, 8'h20, 5, 0, 1);
        add(0, 8'h00, 8'h00, 5, 0, 0);
        add(1, 8'h00, 8'h00, 0, 0, 0);   // reset
        add(0, 8'h80, 8'h00, 7, 1, 1);   // grant 7
        add(0, 8'h81, 8'h80, 7, 0, 1);
        add(0, 8'h81, 8'h00, 7, 0, 0);
        add(0, 8'h81, 8'h00, 0, 1, 1);   // wrap 7 -> 0
        add(0, 8'h81, 8'h01, 0, 0, 1);
        add(0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h10, 8'h00, 4, 1, 1);   // grant 4
        add(1, 8'h10, 8'h00, 0, 0, 0);   // rst wins over held grant
        add(0, 8'h11, 8'h00, 0, 1, 1);   // pointer back to 7 -> 0 first
        add(0, 8'h11, 8'h01, 0, 0, 1);
        add(0, 8'h11, 8'h00, 0, 0, 0);
        add(0, 8'h11, 8'h00, 4, 1, 1);   // then 4
        add(0, 8'h00, 8'h00, 4, 0, 1);   // req[4] dropped
        add(0, 8'h00, 8'h00, 4, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].req, vq[i].done);
            check("vec", i, vq[i].exp_in, vq[i].exp_en, vq[i].exp_busy, vq[i].exp_to);
        end

        // All requesting: order 0..7,0 with dec_en low between grants
        step(1, 8'h00, 8'h00);
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            logic [7:0] dn;
            e = 3'(k % 8);
            dn = 8'h01 << e;
            step(0, 8'hFF, 8'h00);
            check("rr_grant", k, e, 1, 1, 0);
            step(0, 8'hFF, dn);
            check("rr_gap", k, e, 0, 1, 0);
            step(0, 8'hFF, 8'h00);
            check("rr_idle", k, e, 0, 0, 0);
        end

        // Owner never releases
        step(1, 8'h00, 8'h00);
        hi = 0; to_cnt = 0; fell = 0;
        for (int k = 0; k < 100 && fell == 0; k++) begin
            step(0, 8'h01, 8'h00);
            if (timeout) to_cnt++;
            if (dec_en) hi++;
            else if (hi > 0) fell = 1;
        end
`ifdef DEC_ARB_TIMEOUT_EN
        check_int("hold_cycles_high", hi, 16);
        check_int("hold_fell", fell, 1);
        check_int("timeout_pulses", to_cnt, 1);
        check("timeout_at_fall", 0, 0, 0, 1, 1);
        step(0, 8'h00, 8'h00);
        check("timeout_cleared", 0, 0, 0, 0, 0);

        // Release on the expiry cycle: normal release wins
        step(1, 8'h00, 8'h00);
        step(0, 8'h01, 8'h00);
        for (int k = 2; k <= 16; k++) step(0, 8'h01, 8'h00);
        check("hold_cycle16", 0, 0, 1, 1, 0);
        step(0, 8'h01, 8'h01);
        check("release_beats_timeout", 0, 0, 0, 1, 0);
`else
        check_int("hold_cycles_high", hi, 100);
        check_int("hold_fell", fell, 0);
        check_int("timeout_pulses", to_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
